eba_seq_ctrl: RTL and testbench



---
 rtl/eba_seq_ctrl.sv | 115 +++++++++++
 tb/tb_eba_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/eba_seq_ctrl.sv
// Byte-serial sequencer driving an external 8-bit adder for one wide add.
// Optional signed-overflow output is enabled by defining EBA_SEQ_OVF_EN.
module eba_seq_ctrl #(
    parameter int NBYTES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [8*NBYTES-1:0]   i_op_a,
    input  logic [8*NBYTES-1:0]   i_op_b,
    input  logic                  i_op_cin,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [8*NBYTES-1:0]   o_sum,
    output logic                  o_cout,
`ifdef EBA_SEQ_OVF_EN
    output logic                  o_ovf,
`endif
    output logic [7:0]            o_add_a,
    output logic [7:0]            o_add_b,
    output logic                  o_add_cin,
    input  logic [7:0]            i_add_s,
    input  logic                  i_add_cout
);

    localparam int IW = $clog2(NBYTES);
    localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  r_state;
    logic [IW-1:0]           r_idx;
    logic                    r_carry;
    logic [NBYTES-1:0][7:0]  r_a;
    logic [NBYTES-1:0][7:0]  r_b;
    logic [NBYTES-1:0][7:0]  r_sum;
    logic                    r_cout;
    logic                    r_busy;
    logic                    r_done;
    logic                    w_run;

    assign w_run     = (r_state == RUN);
    assign o_add_a   = w_run ? r_a[r_idx] : 8'h00;
    assign o_add_b   = w_run ? r_b[r_idx] : 8'h00;
    assign o_add_cin = w_run ? r_carry : 1'b0;
    assign o_sum     = r_sum;
    assign o_cout    = r_cout;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_a     <= i_op_a;
                        r_b     <= i_op_b;
                        r_carry <= i_op_cin;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    r_sum[r_idx] <= i_add_s;
                    r_carry      <= i_add_cout;
                    if (r_idx == LAST) begin
                        // idx parks at 0 rather than stepping past the last byte
                        r_idx   <= '0;
                        r_cout  <= i_add_cout;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef EBA_SEQ_OVF_EN
    logic r_ovf;
    assign o_ovf = r_ovf;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ovf <= 1'b0;
        end else if (w_run && r_idx == LAST) begin
            r_ovf <= (r_a[NBYTES-1][7] == r_b[NBYTES-1][7]) &&
                     (i_add_s[7] != r_a[NBYTES-1][7]);
        end
    end
`endif

endmodule

// File: tb/tb_eba_seq_ctrl.sv
// Directed bench for eba_seq_ctrl with a behavioural 8-bit adder attached.
// Overflow checks are active when EBA_SEQ_OVF_EN is defined.
module tb_eba_seq_ctrl;

    localparam int NB = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [31:0]   op_a;
    logic [31:0]   op_b;
    logic          op_cin;
    logic          busy;
    logic          done;
    logic [31:0]   sum;
    logic          cout;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_s;
    logic          add_cout;
`ifdef EBA_SEQ_OVF_EN
    logic          ovf;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // the shared 8-bit ripple adder
    assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

    eba_seq_ctrl #(.NBYTES(NB)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_start    (start),
        .i_op_a     (op_a),
        .i_op_b     (op_b),
        .i_op_cin   (op_cin),
        .o_busy     (busy),
        .o_done     (done),
        .o_sum      (sum),
        .o_cout     (cout),
`ifdef EBA_SEQ_OVF_EN
        .o_ovf      (ovf),
`endif
        .o_add_a    (add_a),
        .o_add_b    (add_b),
        .o_add_cin  (add_cin),
        .i_add_s    (add_s),
        .i_add_cout (add_cout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One full add; optionally keeps start high with a junk operand throughout.
    task automatic run_add(input logic [31:0] a, input logic [31:0] b,
                           input logic cin, input logic [3:0] exp_cin,
                           input logic [31:0] exp_sum, input logic exp_cout,
                           input logic exp_ovf, input logic spam);
        op_a   = a;
        op_b   = b;
        op_cin = cin;
        start  = 1'b1;
        tick();
        if (spam) op_a = 32'hFFFF_FFFF;
        else start = 1'b0;
        for (int k = 0; k < NB; k++) begin
            chk($sformatf("run_busy%0d", k), busy, 1'b1);
            chk($sformatf("run_done%0d", k), done, 1'b0);
            chk($sformatf("add_a%0d", k), add_a, a[8*k +: 8]);
            chk($sformatf("add_cin%0d", k), add_cin, exp_cin[k]);
            tick();
        end
        chk("done_hi", done, 1'b1);
        chk("done_busy", busy, 1'b1);
        chk("sum", sum, exp_sum);
        chk("cout", cout, exp_cout);
`ifdef EBA_SEQ_OVF_EN
        chk("ovf", ovf, exp_ovf);
`else
        if (exp_ovf) begin end
`endif
        tick();
        start = 1'b0;
        chk("done_lo", done, 1'b0);
        chk("idle_busy", busy, 1'b0);
        chk("idle_add_a", add_a, 8'h00);
        chk("idle_sum", sum, exp_sum);
    endtask

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        op_a   = '0;
        op_b   = '0;
        op_cin = 1'b0;
        tick();
        tick();
        chk("rst_sum", sum, 32'h0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_add", {add_a, add_b, add_cin}, 17'h0);
`ifdef EBA_SEQ_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // carry out of byte 0 only
        run_add(32'h0000_00FF, 32'h0000_0001, 1'b0, 4'b0010,
                32'h0000_0100, 1'b0, 1'b0, 1'b0);
        // carry ripples through every byte
        run_add(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 4'b1111,
                32'h0000_0000, 1'b1, 1'b0, 1'b0);
        // start held with a different op_a during RUN and DONE
        run_add(32'h1234_5678, 32'h1111_1111, 1'b0, 4'b0000,
                32'h2345_6789, 1'b0, 1'b0, 1'b1);
        tick();
        chk("nolatch_busy", busy, 1'b0);
        chk("nolatch_done", done, 1'b0);

        // reset in RUN at idx=2
        op_a  = 32'h0101_0101;
        op_b  = 32'h0101_0101;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("pre_rst_add_a", add_a, 8'h01);
        chk("pre_rst_sum", sum[15:0], 16'h0202);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("abort_sum", sum, 32'h0);
        chk("abort_cout", cout, 1'b0);
        chk("abort_busy", busy, 1'b0);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("abort_nodone%0d", k), done, 1'b0);
            tick();
        end
        run_add(32'h0000_0001, 32'h0000_0001, 1'b0, 4'b0000,
                32'h0000_0002, 1'b0, 1'b0, 1'b0);

        // signed overflow then unsigned carry without overflow
        run_add(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 4'b1110,
                32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run_add(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 4'b1110,
                32'h0000_0000, 1'b1, 1'b0, 1'b0);

        // back-to-back with start held: done every NB+2 cycles
        op_a   = 32'h0001_0001;
        op_b   = 32'h0001_0001;
        op_cin = 1'b0;
        start  = 1'b1;
        for (int t = 1; t <= 18; t++) begin
            tick();
            chk($sformatf("b2b_done%0d", t), done, (t % 6) == 5);
            if ((t % 6) == 5) chk($sformatf("b2b_sum%0d", t), sum, 32'h0002_0002);
        end
        start = 1'b0;
        tick();
        chk("b2b_end_busy", busy, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
